// File: rtl/cic_pkg.sv
// Shared CIC decimator parameters and helpers.
// Provides default widths, ratio, and the accumulator width function.
package cic_pkg;

  function automatic int cic_acc_w(int in_w, int n, int r);
    return in_w + n * $clog2(r);
  endfunction

  localparam int CIC_IN_W  = 16;
  localparam int CIC_OUT_W = 16;
  localparam int CIC_N     = 4;
  localparam int CIC_R     = 16;
  localparam int CIC_ACC_W = cic_acc_w(CIC_IN_W, CIC_N, CIC_R);

  typedef logic signed [CIC_ACC_W-1:0] cic_acc_t;

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section (M=1): out = x - x_prev, advancing on in_v.
// Ports: clk, rst, in_v/in_d (input), out_v/out_d (registered output).
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = CIC_ACC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_v,
  input  logic signed [W-1:0] in_d,
  output logic                out_v,
  output logic signed [W-1:0] out_d
);

  logic signed [W-1:0] dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      dly   <= '0;
      out_d <= '0;
      out_v <= 1'b0;
    end else begin
      out_v <= in_v;
      if (in_v) begin
        out_d <= in_d - dly;
        dly   <= in_d;
      end
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator by R with rounded, saturated OUT_W output.
// Ports: clk, rst, enable, data_in -> data_out, valid_out strobe.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int IN_W  = CIC_IN_W,
  parameter int OUT_W = CIC_OUT_W,
  parameter int N     = CIC_N,
  parameter int R     = CIC_R,
  parameter int ACC_W = cic_acc_w(IN_W, N, R)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic signed [IN_W-1:0]  data_in,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    valid_out
);

  localparam int CW = $clog2(R);
  localparam logic [ACC_W:0] HALF =
    (ACC_W+1)'(1) << (ACC_W - OUT_W - 1);

  logic signed [ACC_W-1:0] integ [N];
  logic [CW-1:0]           cnt;
  logic                    strobe;
  logic signed [ACC_W-1:0] dec_reg;
  logic                    dec_v;

  logic [N:0]              cv;
  logic [N:0][ACC_W-1:0]   cd;

  logic [ACC_W:0]          rnd;
  logic                    sat;

  for (genvar k = 0; k < N; k++) begin : g_int
    if (k == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst)
          integ[k] <= '0;
        else if (enable)
          integ[k] <= integ[k] + ACC_W'(data_in);
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        if (rst)
          integ[k] <= '0;
        else if (enable)
          integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

  assign strobe = enable && (cnt == CW'(R - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      dec_reg <= '0;
      dec_v   <= 1'b0;
    end else begin
      dec_v <= strobe;
      if (enable)
        cnt <= cnt + 1'b1;
      if (strobe)
        dec_reg <= integ[N-1];
    end
  end

  assign cv[0] = dec_v;
  assign cd[0] = dec_reg;

  for (genvar k = 0; k < N; k++) begin : g_comb
    cic_comb_stage #(
      .W (ACC_W)
    ) u_comb (
      .clk   (clk),
      .rst   (rst),
      .in_v  (cv[k]),
      .in_d  (cd[k]),
      .out_v (cv[k+1]),
      .out_d (cd[k+1])
    );
  end

  // Extra MSB keeps the +half rounding from wrapping; a result with
  // bit ACC_W clear but bit ACC_W-1 set overflowed the positive range.
  assign rnd = {cd[N][ACC_W-1], cd[N]} + HALF;
  assign sat = !rnd[ACC_W] && rnd[ACC_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= cv[N];
      if (cv[N])
        data_out <= sat ? {1'b0, {(OUT_W-1){1'b1}}}
                        : rnd[ACC_W-1 -: OUT_W];
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator (defaults N=4, R=16).
// Reference is a direct 61-tap boxcar^4 FIR evaluated per output.
module tb_cic_decimator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic signed [15:0] data_in = '0;
  logic signed [15:0] data_out;
  logic               valid_out;

  cic_decimator u_dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int val;
    int cycles;
    int settled;
  } vec_t;

  vec_t   tbl [5];
  int     h [0:63];
  int     xs [1:4095];
  int     n_chk = 0;
  int     n_fail = 0;
  int     t = 0;
  int     n = 0;
  int     exp_tick = -1;
  int     exp_data = 0;
  int     last_out = 0;
  int     prev_pulse = -1;
  int     first_pulse = -1;
  int     chk_gap = 0;

  task automatic check(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at tick %0d",
               name, act, exp, t);
    end
  endtask

  function automatic int model(int m);
    longint y = 0;
    longint r;
    for (int j = 0; j < 61; j++) begin
      int idx = 16 * m - 4 - j;
      if (idx >= 1)
        y += longint'(h[j]) * longint'(xs[idx]);
    end
    r = (y + 32768) >>> 16;
    if (r > 32767)
      r = 32767;
    return int'(r);
  endfunction

  task automatic step(input logic en, input logic signed [15:0] d,
                      input logic r);
    rst = r;
    enable = en;
    data_in = d;
    @(posedge clk);
    #1;
    t++;
    if (r) begin
      n = 0;
      exp_tick = -1;
      last_out = 0;
      prev_pulse = -1;
      first_pulse = -1;
    end else if (en && n < 4095) begin
      n++;
      xs[n] = int'(d);
      if (n % 16 == 0) begin
        exp_tick = t + 5;
        exp_data = model(n / 16);
      end
    end
    check("valid_out", longint'(valid_out), longint'(t == exp_tick));
    if (t == exp_tick)
      last_out = exp_data;
    check("data_out", longint'(data_out), longint'(last_out));
    if (valid_out) begin
      if (prev_pulse >= 0 && chk_gap > 0)
        check("pulse_gap", longint'(t - prev_pulse), longint'(chk_gap));
      prev_pulse = t;
      if (first_pulse < 0)
        first_pulse = t;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 16'sd0, 1'b1);
    step(1'b0, 16'sd0, 1'b1);
  endtask

  initial begin
    int a [0:63];
    int b [0:63];
    int rel;

    for (int k = 0; k < 64; k++)
      a[k] = (k < 16) ? 1 : 0;
    repeat (3) begin
      for (int k = 0; k < 64; k++) begin
        b[k] = 0;
        for (int j = 0; j < 16; j++)
          if (k - j >= 0)
            b[k] += a[k-j];
      end
      a = b;
    end
    h = a;

    tbl[0] = '{1, 1000, 200, 1000};
    tbl[1] = '{1, -32768, 200, -32768};
    tbl[2] = '{1, 32767, 200, 32767};
    tbl[3] = '{3, 1000, 700, 1000};
    tbl[4] = '{1, -1, 200, -1};

    // Reset held with live input; first pulse 16 samples + 5 later.
    repeat (3) step(1'b1, 16'sh1234, 1'b1);
    check("rst_data_out", longint'(data_out), 0);
    check("rst_valid_out", longint'(valid_out), 0);
    rel = t;
    chk_gap = 16;
    for (int i = 0; i < 120; i++)
      step(1'b1, 16'sd1000, 1'b0);
    check("first_pulse_lat", longint'(first_pulse - rel), 21);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      chk_gap = 16 * tbl[v].period;
      for (int i = 0; i < tbl[v].cycles; i++)
        step((i % tbl[v].period) == tbl[v].period - 1,
             16'(tbl[v].val), 1'b0);
      check($sformatf("settled_%0d", v),
            longint'(data_out), longint'(tbl[v].settled));
    end

    // Reset after 7 of 16 samples must drop the partial frame.
    do_reset();
    chk_gap = 16;
    for (int i = 0; i < 7; i++)
      step(1'b1, 16'sd1000, 1'b0);
    step(1'b1, 16'sd1000, 1'b1);
    rel = t;
    for (int i = 0; i < 120; i++)
      step(1'b1, 16'sd500, 1'b0);
    check("midrst_first_pulse", longint'(first_pulse - rel), 21);
    check("midrst_settled", longint'(data_out), 500);

    // Random full-scale input with gaps; drives integrators into wrap.
    do_reset();
    chk_gap = 0;
    for (int i = 0; i < 3000; i++) begin
      logic signed [15:0] d;
      case ($urandom_range(0, 3))
        0: d = 16'sh7FFF;
        1: d = 16'sh8000;
        default: d = 16'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, d, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
